// File: rtl/pwm_capture.sv
// pwm_capture: measures period and duty (0-100 %) of an async PWM pin.
// Optional glitch filter: define PWM_CAP_FILTER_EN (depth FILT_LEN).
// Ports: I_clk, I_rst_n (async, active-low), I_en, I_pwm (async pin),
//   O_duty[7:0], O_period[CNT_W-1:0], O_valid (strobe), O_timeout.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int FILT_LEN    = 4
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_en,
  input  logic             I_pwm,
  output logic [7:0]       O_duty,
  output logic [CNT_W-1:0] O_period,
  output logic             O_valid,
  output logic             O_timeout
);

  localparam int DW = CNT_W + 7;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEASURE
  } state_t;

  logic s1, s2;
  logic lvl;
  logic lvl_r;
  logic rise_r;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= I_pwm;
      s2 <= s1;
    end
  end

`ifdef PWM_CAP_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] f_cnt;
  logic          f_lvl;

  // Level follows s2 only once it has disagreed FILT_LEN samples in a row.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      f_cnt <= '0;
      f_lvl <= 1'b0;
    end else if (s2 == f_lvl) begin
      f_cnt <= '0;
    end else if (f_cnt == FW'(FILT_LEN - 1)) begin
      f_cnt <= '0;
      f_lvl <= s2;
    end else begin
      f_cnt <= f_cnt + FW'(1);
    end
  end

  assign lvl = f_lvl;
`else
  assign lvl = s2;
`endif

  // rise_r and lvl_r describe the same sample, so the FSM sees a
  // consistent level/edge pair.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      lvl_r  <= 1'b0;
      rise_r <= 1'b0;
    end else begin
      lvl_r  <= lvl;
      rise_r <= lvl & ~lvl_r;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic             div_busy;
  logic [3:0]       div_step;
  logic [DW-1:0]    div_rem;
  logic [DW-1:0]    div_den;
  logic [7:0]       div_q;
  logic [CNT_W-1:0] div_per;

  logic [CNT_W-1:0] per_next;
  logic [CNT_W-1:0] hi_total;
  logic             div_free;
  logic             timed_out;

  // The cycle that carries the rising edge is always high, so it
  // closes the high count of the period that ends there.
  assign per_next  = period_cnt + CNT_W'(1);
  assign hi_total  = high_cnt + CNT_W'(lvl_r);
  assign div_free  = !div_busy || (div_step == 4'd8);
  assign timed_out = (period_cnt == TO_LAST);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      div_busy   <= 1'b0;
      div_step   <= '0;
      div_rem    <= '0;
      div_den    <= '0;
      div_q      <= '0;
      div_per    <= '0;
      O_duty     <= '0;
      O_period   <= '0;
      O_valid    <= 1'b0;
      O_timeout  <= 1'b0;
    end else begin
      O_valid <= 1'b0;
      if (!I_en) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        div_busy   <= 1'b0;
      end else begin
        // Restoring divide: quotient < 256, so 8 shifted-divisor
        // steps starting at period<<7 are enough.
        if (div_busy) begin
          if (div_step == 4'd8) begin
            O_duty    <= div_q;
            O_period  <= div_per;
            O_valid   <= 1'b1;
            O_timeout <= 1'b0;
            div_busy  <= 1'b0;
          end else begin
            if (div_rem >= div_den) begin
              div_rem <= div_rem - div_den;
              div_q   <= {div_q[6:0], 1'b1};
            end else begin
              div_q   <= {div_q[6:0], 1'b0};
            end
            div_den  <= div_den >> 1;
            div_step <= div_step + 4'd1;
          end
        end

        unique case (state)
          IDLE: begin
            state <= WAIT_RISE;
          end
          WAIT_RISE, MEASURE: begin
            if (rise_r) begin
              // A result finishing this cycle frees the divider.
              if (state == MEASURE && div_free) begin
                div_busy <= 1'b1;
                div_step <= '0;
                div_q    <= '0;
                div_rem  <= DW'(hi_total) * DW'(100);
                div_den  <= {per_next, 7'b0};
                div_per  <= per_next;
              end
              period_cnt <= '0;
              high_cnt   <= '0;
              state      <= MEASURE;
            end else if (timed_out) begin
              O_duty     <= lvl_r ? 8'd100 : 8'd0;
              O_period   <= '0;
              O_timeout  <= 1'b1;
              O_valid    <= 1'b1;
              div_busy   <= 1'b0;
              period_cnt <= '0;
              high_cnt   <= '0;
              state      <= WAIT_RISE;
            end else begin
              period_cnt <= per_next;
              high_cnt   <= hi_total;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed scenarios for pwm_capture.
// Each report is logged with its cycle and checked against hand values.
module tb_pwm_capture;

  localparam int T = 2000;
`ifdef PWM_CAP_FILTER_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 12;
`endif
  localparam int DET = LAT - 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pwm = 1'b0;
  logic [7:0]  duty;
  logic [31:0] period;
  logic        valid;
  logic        tout;

  pwm_capture #(
    .CNT_W(32),
    .TIMEOUT_CYC(T),
    .FILT_LEN(4)
  ) dut (
    .I_clk(clk),
    .I_rst_n(rst_n),
    .I_en(en),
    .I_pwm(pwm),
    .O_duty(duty),
    .O_period(period),
    .O_valid(valid),
    .O_timeout(tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [7:0]  duty;
    logic [31:0] per;
    logic        to;
  } rec_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  rec_t vq[$];
  rec_t ex[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && valid) vq.push_back('{cyc, duty, period, tout});
  end

  function automatic rec_t mk(int c, int d, int p, logic t);
    rec_t r;
    r.cyc = c;
    r.duty = 8'(d);
    r.per = 32'(p);
    r.to = t;
    return r;
  endfunction

  task automatic step(input logic v);
    @(negedge clk);
    pwm = v;
  endtask

  task automatic steps(input logic v, input int n);
    repeat (n) step(v);
  endtask

  task automatic rise(output int r);
    @(negedge clk);
    pwm = 1'b1;
    r = cyc + 1;
  endtask

  task automatic restart;
    @(negedge clk);
    en = 1'b0;
    pwm = 1'b0;
    steps(1'b0, 5);
    en = 1'b1;
    steps(1'b0, 10);
    vq.delete();
    ex.delete();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (duty !== 8'd0) begin
      failures++;
      $display("FAIL reset_duty got %0d want 0", duty);
    end
    checks++;
    if (period !== 32'd0) begin
      failures++;
      $display("FAIL reset_period got %0d want 0", period);
    end
    checks++;
    if (valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got %0b want 0", valid);
    end
    checks++;
    if (tout !== 1'b0) begin
      failures++;
      $display("FAIL reset_timeout got %0b want 0", tout);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int r[5];
    restart();
    for (int i = 0; i < 5; i++) begin
      rise(r[i]);
      steps(1'b1, 249);
      steps(1'b0, 750);
    end
    for (int i = 1; i < 5; i++) ex.push_back(mk(r[i] + LAT, 25, 1000, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL basic_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL basic[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask

`ifndef PWM_CAP_FILTER_EN
  task automatic test_fast;
    int a0;
    int rf[12];
    restart();
    rise(a0);
    steps(1'b1, 249);
    steps(1'b0, 750);
    for (int i = 0; i < 12; i++) begin
      rise(rf[i]);
      steps(1'b0, 2);
    end
    steps(1'b0, 30);
    ex.push_back(mk(rf[0] + LAT, 25, 1000, 1'b0));
    ex.push_back(mk(rf[3] + LAT, 33, 3, 1'b0));
    ex.push_back(mk(rf[6] + LAT, 33, 3, 1'b0));
    ex.push_back(mk(rf[9] + LAT, 33, 3, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL fast_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL fast[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask

  task automatic test_short;
    int s0, s1, s2, s3;
    restart();
    rise(s0);
    steps(1'b1, 499);
    steps(1'b0, 500);
    rise(s1);
    steps(1'b1, 1);
    steps(1'b0, 3);
    rise(s2);
    steps(1'b1, 299);
    steps(1'b0, 700);
    rise(s3);
    steps(1'b1, 29);
    ex.push_back(mk(s1 + LAT, 50, 1000, 1'b0));
    ex.push_back(mk(s3 + LAT, 30, 1000, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL short_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL short[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask
`else
  task automatic test_glitch;
    int f[3];
    restart();
    for (int i = 0; i < 2; i++) begin
      rise(f[i]);
      steps(1'b1, 199);
      steps(1'b0, 2);
      steps(1'b1, 298);
      steps(1'b0, 500);
    end
    rise(f[2]);
    steps(1'b1, 29);
    ex.push_back(mk(f[1] + LAT, 50, 1000, 1'b0));
    ex.push_back(mk(f[2] + LAT, 50, 1000, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL glitch_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL glitch[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask
`endif

  task automatic test_timeout;
    int h0, h1, c0, c1;
    restart();
    rise(h0);
    steps(1'b1, 99);
    steps(1'b0, 100);
    rise(h1);
    while (cyc < h1 + 2 * T + 20) step(1'b1);
    while (cyc < h1 + 3 * T + 20) step(1'b0);
    rise(c0);
    steps(1'b1, 99);
    steps(1'b0, 100);
    rise(c1);
    steps(1'b1, 29);
    ex.push_back(mk(h1 + LAT, 50, 200, 1'b0));
    ex.push_back(mk(h1 + DET + T, 100, 0, 1'b1));
    ex.push_back(mk(h1 + DET + 2 * T, 100, 0, 1'b1));
    ex.push_back(mk(h1 + DET + 3 * T, 0, 0, 1'b1));
    ex.push_back(mk(c1 + LAT, 50, 200, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL timeout_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL timeout[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask

  task automatic test_disable;
    int d0, d1, e0, g0, g1;
    restart();
    rise(d0);
    steps(1'b1, 449);
    steps(1'b0, 550);
    rise(d1);
    steps(1'b1, 599);
    steps(1'b0, 400);
    rise(e0);
    steps(1'b1, 7);
    en = 1'b0;
    steps(1'b1, 40);
    checks++;
    if (duty !== 8'd45 || period !== 32'd1000 || tout !== 1'b0) begin
      failures++;
      $display("FAIL disable_hold got d=%0d p=%0d t=%0b want d=45 p=1000 t=0",
               duty, period, tout);
    end
    en = 1'b1;
    steps(1'b1, 552);
    steps(1'b0, 400);
    rise(g0);
    steps(1'b1, 199);
    steps(1'b0, 800);
    rise(g1);
    steps(1'b1, 29);
    ex.push_back(mk(d1 + LAT, 45, 1000, 1'b0));
    ex.push_back(mk(g1 + LAT, 20, 1000, 1'b0));
    checks++;
    if (vq.size() != ex.size()) begin
      failures++;
      $display("FAIL disable_count got %0d want %0d", vq.size(), ex.size());
    end
    for (int i = 0; i < ex.size() && i < vq.size(); i++) begin
      checks++;
      if (vq[i].cyc !== ex[i].cyc || vq[i].duty !== ex[i].duty ||
          vq[i].per !== ex[i].per || vq[i].to !== ex[i].to) begin
        failures++;
        $display("FAIL disable[%0d] got c=%0d d=%0d p=%0d t=%0b want c=%0d d=%0d p=%0d t=%0b",
                 i, vq[i].cyc, vq[i].duty, vq[i].per, vq[i].to,
                 ex[i].cyc, ex[i].duty, ex[i].per, ex[i].to);
      end
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (duty !== 8'd0) begin
      failures++;
      $display("FAIL async_reset_duty got %0d want 0", duty);
    end
    checks++;
    if (period !== 32'd0) begin
      failures++;
      $display("FAIL async_reset_period got %0d want 0", period);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
`ifndef PWM_CAP_FILTER_EN
    test_fast();
    test_short();
`else
    test_glitch();
`endif
    test_timeout();
    test_disable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
